// File: rtl/jtframe_db15_sched.sv
// -----------------------------------------------------------------------------
// jtframe_db15_sched
//
// Scheduler for the DB15 serial joystick reader. It produces the reader's
// clock enable and scan window, watches every scan with a timeout watchdog,
// and picks, cycle by cycle, whether the core sees DB15 data or the USB/OSD
// joystick data. It sits between the MiSTer top level and the db15 reader.
//
// Optional feature macro: JTFRAME_DB15_DEBOUNCE_EN
//   Defined     : a sample is copied to the DB buffer only when two scans in
//                 a row return the same value.
//   Not defined : every sample is copied to the DB buffer directly.
//
// Parameters
//   CENDIV    clk cycles per reader clock-enable pulse (>=2)
//   SCAN_GAP  cen pulses spent idle between two scans (>=1)
//   TIMEOUT   cen pulses allowed in SCAN before the scan is aborted
//   MAXFAIL   consecutive timeouts before DB15 is declared lost
//
// Ports
//   rst             asynchronous reset, active high
//   clk             system clock
//   i_enable        DB15 support enabled from the OSD; low selects USB only
//   i_usb_joy0/1    USB joysticks, active high, 12 bits each
//   o_db_cen        one-clk-wide clock enable for the reader
//   o_db_scan       scan request for the reader
//   i_db_sample     reader strobe: new data valid
//   i_db_hooked     reader has detected a controller
//   i_db_joy0/1     reader data for players 0 and 1
//   o_joy0/1        registered joystick data selected for the core
//   o_db15_active   high while DB15 data drives o_joy0/o_joy1
//   o_timeout_err   one-cycle pulse when a scan is aborted
// -----------------------------------------------------------------------------
module jtframe_db15_sched #(
    parameter int CENDIV   = 16,
    parameter int SCAN_GAP = 256,
    parameter int TIMEOUT  = 64,
    parameter int MAXFAIL  = 3
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        i_enable,
    input  logic [11:0] i_usb_joy0,
    input  logic [11:0] i_usb_joy1,
    output logic        o_db_cen,
    output logic        o_db_scan,
    input  logic        i_db_sample,
    input  logic        i_db_hooked,
    input  logic [11:0] i_db_joy0,
    input  logic [11:0] i_db_joy1,
    output logic [11:0] o_joy0,
    output logic [11:0] o_joy1,
    output logic        o_db15_active,
    output logic        o_timeout_err
);

    localparam int CW = $clog2(CENDIV);
    localparam int GW = $clog2(SCAN_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(MAXFAIL + 1);

    localparam logic [CW-1:0] CEN_LAST = CW'(CENDIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(SCAN_GAP - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAXFAIL);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [CW-1:0] r_cenCnt;
    logic [GW-1:0] r_gapCnt;
    logic [TW-1:0] r_toCnt;
    logic [FW-1:0] r_failCnt;
    logic [1:0]    r_state;
    logic          r_lost;
    logic          r_scan;
    logic          r_toErr;
    logic          r_active;
    logic [11:0]   r_buf0;
    logic [11:0]   r_buf1;
    logic [11:0]   r_joy0;
    logic [11:0]   r_joy1;

    logic          w_cen;
    logic [FW-1:0] w_failNext;

    assign w_cen      = (r_cenCnt == CEN_LAST);
    assign w_failNext = (r_failCnt == FAIL_MAX) ? r_failCnt : r_failCnt + FW'(1);

    assign o_db_cen      = w_cen;
    assign o_db_scan     = r_scan;
    assign o_timeout_err = r_toErr;
    assign o_db15_active = r_active;
    assign o_joy0        = r_joy0;
    assign o_joy1        = r_joy1;

    // Free-running divider; the reader depends on a steady shift rate, so it
    // is never gated by enable or the FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cenCnt <= '0;
        end else if (w_cen) begin
            r_cenCnt <= '0;
        end else begin
            r_cenCnt <= r_cenCnt + CW'(1);
        end
    end

    // Scan scheduler. r_scan is updated together with the state so that the
    // scan request follows the state register exactly, one clk after the
    // decision. A sample in SCAN wins over a timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gapCnt  <= '0;
            r_toCnt   <= '0;
            r_failCnt <= '0;
            r_lost    <= 1'b1;
            r_scan    <= 1'b0;
            r_toErr   <= 1'b0;
        end else begin
            r_toErr <= 1'b0;
            if (!i_enable) begin
                r_state   <= ST_IDLE;
                r_gapCnt  <= '0;
                r_toCnt   <= '0;
                r_failCnt <= '0;
                r_lost    <= 1'b1;
                r_scan    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cen) begin
                            if (r_gapCnt == GAP_LAST) begin
                                r_gapCnt <= '0;
                                r_state  <= ST_SCAN;
                                r_scan   <= 1'b1;
                            end else begin
                                r_gapCnt <= r_gapCnt + GW'(1);
                            end
                        end
                    end
                    ST_SCAN: begin
                        if (i_db_sample) begin
                            r_toCnt <= '0;
                            r_state <= ST_LATCH;
                            r_scan  <= 1'b0;
                        end else if (w_cen) begin
                            if (r_toCnt == TO_LAST) begin
                                r_toCnt   <= '0;
                                r_toErr   <= 1'b1;
                                r_state   <= ST_GAP;
                                r_scan    <= 1'b0;
                                r_failCnt <= w_failNext;
                                r_lost    <= r_lost | (w_failNext == FAIL_MAX);
                            end else begin
                                r_toCnt <= r_toCnt + TW'(1);
                            end
                        end
                    end
                    ST_LATCH: begin
                        r_failCnt <= '0;
                        r_lost    <= 1'b0;
                        r_state   <= ST_GAP;
                    end
                    ST_GAP: begin
                        // one idle cycle with scan low lets the reader rearm
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_scan  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef JTFRAME_DB15_DEBOUNCE_EN
    logic [11:0] r_prev0;
    logic [11:0] r_prev1;
    logic        r_prevValid;

    // The buffer only takes a sample that matches the previous scan. After
    // reset or re-enable the first sample just primes the comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_prev0     <= '0;
            r_prev1     <= '0;
            r_prevValid <= 1'b0;
        end else if (!i_enable) begin
            r_prevValid <= 1'b0;
        end else if (r_state == ST_LATCH) begin
            r_prev0     <= i_db_joy0;
            r_prev1     <= i_db_joy1;
            r_prevValid <= 1'b1;
            if (r_prevValid && i_db_joy0 == r_prev0 && i_db_joy1 == r_prev1) begin
                r_buf0 <= i_db_joy0;
                r_buf1 <= i_db_joy1;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else if (i_enable && r_state == ST_LATCH) begin
            r_buf0 <= i_db_joy0;
            r_buf1 <= i_db_joy1;
        end
    end
`endif

    // Source select. The mux uses the registered active flag, so a change of
    // source reaches the joystick outputs one cycle after o_db15_active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_joy0   <= '0;
            r_joy1   <= '0;
        end else begin
            r_active <= i_enable & i_db_hooked & ~r_lost;
            if (r_active) begin
                r_joy0 <= r_buf0;
                r_joy1 <= r_buf1;
            end else begin
                r_joy0 <= i_usb_joy0;
                r_joy1 <= i_usb_joy1;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_db15_sched.sv
// -----------------------------------------------------------------------------
// tb_jtframe_db15_sched
//
// Bench for jtframe_db15_sched with CENDIV=4, SCAN_GAP=8, TIMEOUT=64,
// MAXFAIL=3. A small reader model answers scan requests; expected joystick
// values are queued when the reader delivers a sample (or when USB data is
// driven) and compared once the DUT outputs have settled.
// -----------------------------------------------------------------------------
module tb_jtframe_db15_sched;

    localparam int CENDIV   = 4;
    localparam int SCAN_GAP = 8;
    localparam int TIMEOUT  = 64;
    localparam int MAXFAIL  = 3;

    logic        rst;
    logic        clk;
    logic        enable;
    logic [11:0] usbJoy0;
    logic [11:0] usbJoy1;
    logic        dbCen;
    logic        dbScan;
    logic        dbSample;
    logic        dbHooked;
    logic [11:0] dbJoy0;
    logic [11:0] dbJoy1;
    logic [11:0] joy0;
    logic [11:0] joy1;
    logic        db15Active;
    logic        timeoutErr;

    int total = 0;
    int bad   = 0;

    logic [23:0] sbQueue[$];

    logic [11:0] mBuf0 = '0;
    logic [11:0] mBuf1 = '0;
    logic [11:0] mPrev0 = '0;
    logic [11:0] mPrev1 = '0;
    bit          mPrevValid = 1'b0;

    jtframe_db15_sched #(
        .CENDIV   (CENDIV),
        .SCAN_GAP (SCAN_GAP),
        .TIMEOUT  (TIMEOUT),
        .MAXFAIL  (MAXFAIL)
    ) dut (
        .rst           (rst),
        .clk           (clk),
        .i_enable      (enable),
        .i_usb_joy0    (usbJoy0),
        .i_usb_joy1    (usbJoy1),
        .o_db_cen      (dbCen),
        .o_db_scan     (dbScan),
        .i_db_sample   (dbSample),
        .i_db_hooked   (dbHooked),
        .i_db_joy0     (dbJoy0),
        .i_db_joy1     (dbJoy1),
        .o_joy0        (joy0),
        .o_joy1        (joy1),
        .o_db15_active (db15Active),
        .o_timeout_err (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic hooked,
                                 input logic [11:0] u0, input logic [11:0] u1);
        enable   = en;
        dbHooked = hooked;
        usbJoy0  = u0;
        usbJoy1  = u1;
    endtask

    // Reference for what the DB buffer should hold after a sample
    task automatic modelSample(input logic [11:0] j0, input logic [11:0] j1);
`ifdef JTFRAME_DB15_DEBOUNCE_EN
        if (mPrevValid && j0 == mPrev0 && j1 == mPrev1) begin
            mBuf0 = j0;
            mBuf1 = j1;
        end
        mPrev0     = j0;
        mPrev1     = j1;
        mPrevValid = 1'b1;
`else
        mBuf0 = j0;
        mBuf1 = j1;
`endif
        sbQueue.push_back({mBuf1, mBuf0});
    endtask

    task automatic waitScan(input string tag);
        int n = 0;
        while (!dbScan && n < 400) begin
            step();
            n++;
        end
        checkOutput(tag, 32'(dbScan), 1);
    endtask

    // Reader model: counts cen pulses during the scan window and optionally
    // strobes a sample on the chosen pulse.
    task automatic runScan(input bit doSample, input int sampleAt,
                           input logic [11:0] j0, input logic [11:0] j1,
                           output int cens, output bit sawErr);
        cens   = 0;
        sawErr = 1'b0;
        waitScan("scanStart");
        dbJoy0 = j0;
        dbJoy1 = j1;
        for (int i = 0; i < 2000; i++) begin
            if (timeoutErr) begin
                sawErr = 1'b1;
                break;
            end
            if (!dbScan) break;
            if (dbCen) begin
                cens++;
                if (doSample && cens == sampleAt) begin
                    dbSample = 1'b1;
                    modelSample(j0, j1);
                end
            end
            step();
            dbSample = 1'b0;
        end
    endtask

    task automatic settleAndCompare(input string tag);
        logic [23:0] exp;
        repeat (6) step();
        if (sbQueue.size() == 0) begin
            checkOutput({tag, "Queue"}, 0, 1);
        end else begin
            exp = sbQueue.pop_front();
            checkOutput(tag, 32'({joy1, joy0}), 32'(exp));
        end
        checkOutput({tag, "Active"}, 32'(db15Active), 1);
    endtask

    initial begin
        int  n;
        bit  e;
        logic [11:0] r0;
        logic [11:0] r1;

        rst      = 1'b1;
        dbSample = 1'b0;
        dbJoy0   = '0;
        dbJoy1   = '0;
        applyStimulus(1'b1, 1'b1, 12'h0F0, 12'h00F);

        // reset state
        repeat (3) step();
        checkOutput("resetOutputs",
                    32'({joy1, joy0, dbCen, dbScan, db15Active, timeoutErr}), 0);
        rst = 1'b0;

        // 1: cen cadence and first scan after SCAN_GAP cen pulses
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k <= 16) checkOutput("cenCadence", 32'(dbCen), (k % 4 == 3) ? 1 : 0);
            if (k == 2)  checkOutput("usbAfterReset", 32'({joy1, joy0}), 32'h00F0F0);
            if (k == 31) checkOutput("scanBeforeGap", 32'(dbScan), 0);
            if (k == 32) checkOutput("scanAfterGap", 32'(dbScan), 1);
        end

        // 2: good scan, sample after 52 cen
        runScan(1'b1, 52, 12'h010, 12'h00A, n, e);
        checkOutput("t2Cens", 32'(n), 52);
        checkOutput("t2NoErr", 32'(e), 0);
        settleAndCompare("t2Joy");

        // 3: reader never answers, three aborts lose DB15
        for (int a = 1; a <= MAXFAIL; a++) begin
            runScan(1'b0, 0, 12'h3FF, 12'h3FF, n, e);
            checkOutput("t3Err", 32'(e), 1);
            checkOutput("t3Cens", 32'(n), TIMEOUT);
            step();
            checkOutput("t3ErrPulse", 32'(timeoutErr), 0);
            repeat (3) step();
            if (a < MAXFAIL) begin
                checkOutput("t3StillActive", 32'(db15Active), 1);
            end else begin
                checkOutput("t3Lost", 32'(db15Active), 0);
                checkOutput("t3UsbJoy0", 32'(joy0), 32'h0F0);
            end
        end

        // 5: sample on the same cen that would time out
        runScan(1'b1, TIMEOUT, 12'h020, 12'h00B, n, e);
        checkOutput("t5Cens", 32'(n), TIMEOUT);
        checkOutput("t5NoErr", 32'(e), 0);
        settleAndCompare("t5Joy");
        for (int b = 1; b < MAXFAIL; b++) begin
            runScan(1'b0, 0, 12'h3FF, 12'h3FF, n, e);
            checkOutput("t5Abort", 32'(e), 1);
        end
        repeat (3) step();
        checkOutput("t5FailCleared", 32'(db15Active), 1);

        // 4: enable dropped mid-scan
        waitScan("t4ScanStart");
        repeat (10) step();
        checkOutput("t4MidScan", 32'(dbScan), 1);
        applyStimulus(1'b0, 1'b1, 12'h5A5, 12'h0C3);
        mPrevValid = 1'b0;
        step();
        checkOutput("t4ScanDrop", 32'(dbScan), 0);
        checkOutput("t4ActiveDrop", 32'(db15Active), 0);
        step();
        checkOutput("t4UsbJoy", 32'({joy1, joy0}), 32'h0C35A5);

        // USB pass-through while disabled, one cycle latency
        for (int i = 0; i < 16; i++) begin
            logic [23:0] exp;
            r0 = 12'($urandom);
            r1 = 12'($urandom);
            sbQueue.push_back({r1, r0});
            applyStimulus(1'b0, 1'b1, r0, r1);
            step();
            exp = sbQueue.pop_front();
            checkOutput("usbPass", 32'({joy1, joy0}), 32'(exp));
        end
        checkOutput("usbScanIdle", 32'(dbScan), 0);

        // re-enable: first scan only after a full gap
        applyStimulus(1'b1, 1'b1, 12'h0F0, 12'h00F);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (dbScan) break;
            if (dbCen) n++;
            step();
        end
        checkOutput("reenGap", 32'(n), SCAN_GAP);
        checkOutput("reenLost", 32'(db15Active), 0);

        // 6: samples 001, 002, 002
        runScan(1'b1, 52, 12'h001, 12'h800, n, e);
        checkOutput("t6Err1", 32'(e), 0);
        settleAndCompare("t6Scan1");
        runScan(1'b1, 52, 12'h002, 12'h800, n, e);
        checkOutput("t6Err2", 32'(e), 0);
        settleAndCompare("t6Scan2");
        runScan(1'b1, 52, 12'h002, 12'h800, n, e);
        checkOutput("t6Err3", 32'(e), 0);
        settleAndCompare("t6Scan3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
